// File: rtl/crc_bit_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC slice: sequencer state encoding and
// default widths used by the bit sequencer, frame counter and LFSR datapath.
// -----------------------------------------------------------------------------
package crc_pkg;

    // Default width of the bit counter / frame length field.
    localparam int CNT_W_DEF = 8;
    // Default width of the completed-frame counter.
    localparam int FRM_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : crc_pkg

// File: rtl/crc_bit_sequencer_if.sv
// -----------------------------------------------------------------------------
// crc_bit_sequencer_if
// Control/status bundle between the frame controller (master) and the bit
// sequencer (slave).
//   master -> slave : start, len, mode_auto, in_valid, abort
//   slave -> master : busy, shift_en, bit_idx, last, done, err_len, frames
// -----------------------------------------------------------------------------
interface crc_bit_sequencer_if
    import crc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int FRM_W = FRM_W_DEF
);

    logic             start;
    logic [CNT_W-1:0] len;
    logic             mode_auto;
    logic             in_valid;
    logic             abort;

    logic             busy;
    logic             shift_en;
    logic [CNT_W-1:0] bit_idx;
    logic             last;
    logic             done;
    logic             err_len;
    logic [FRM_W-1:0] frames;

    modport master (
        output start, len, mode_auto, in_valid, abort,
        input  busy, shift_en, bit_idx, last, done, err_len, frames
    );

    modport slave (
        input  start, len, mode_auto, in_valid, abort,
        output busy, shift_en, bit_idx, last, done, err_len, frames
    );

endinterface : crc_bit_sequencer_if

// File: rtl/crc_bit_sequencer_frame_counter.sv
// -----------------------------------------------------------------------------
// crc_frame_counter
// FRM_W-wide wrap-around counter of completed frames.
//   clk, reset_n : clock, asynchronous active-low reset (count -> 0)
//   i_clr        : synchronous clear, dominates i_inc
//   i_inc        : increment by one, wraps modulo 2**FRM_W
//   o_count      : current count
// -----------------------------------------------------------------------------
module crc_frame_counter
    import crc_pkg::*;
#(
    parameter int FRM_W = FRM_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [FRM_W-1:0] o_count
);

    logic [FRM_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + FRM_W'(1);   // natural wrap at all-ones
        end
    end

    assign o_count = r_count;

endmodule : crc_frame_counter

// File: rtl/crc_bit_sequencer.sv
// -----------------------------------------------------------------------------
// crc_bit_sequencer
// Paces a serial CRC engine: counts len data bits per frame, drives the shift
// enable while input bits are valid, pulses done after the last bit, and can
// auto-repeat frames until aborted.
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : crc_bit_sequencer_if.slave
//              in : start, len, mode_auto, in_valid, abort
//              out: busy, shift_en, bit_idx, last, done, err_len, frames
// Only shift_en and last are combinational (state, in_valid, bit_idx, len_q);
// every other output is registered, so start never reaches an output in the
// same cycle.
// -----------------------------------------------------------------------------
module crc_bit_sequencer
    import crc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int FRM_W = FRM_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    crc_bit_sequencer_if.slave  bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] r_len_q;
    logic             r_auto_q;
    logic             r_busy;
    logic             r_done;
    logic             r_err_len;

    logic             w_shift_en;
    logic             w_last;
    logic             w_frame_inc;
    logic [FRM_W-1:0] w_frames;

    // len_q is never 0 while in RUN, so len_q-1 cannot underflow there.
    assign w_shift_en  = (r_state == RUN) && bus.in_valid;
    assign w_last      = w_shift_en && (r_bit_idx == (r_len_q - CNT_W'(1)));
    // A frame only counts if it completes without a simultaneous abort.
    assign w_frame_inc = w_last && !bus.abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_len_q   <= '0;
            r_auto_q  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err_len <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_err_len <= 1'b0;
            if (bus.abort) begin
                // Abort overrides everything, including a coincident last bit
                // or a start in IDLE.
                r_state   <= IDLE;
                r_bit_idx <= '0;
                r_auto_q  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            if (bus.len != '0) begin
                                r_len_q   <= bus.len;
                                r_auto_q  <= bus.mode_auto;
                                r_bit_idx <= '0;
                                r_state   <= RUN;
                                r_busy    <= 1'b1;
                            end else begin
                                r_err_len <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (w_shift_en) begin
                            if (w_last) begin
                                r_bit_idx <= '0;
                                r_state   <= DONE;
                                r_done    <= 1'b1;
                            end else begin
                                r_bit_idx <= r_bit_idx + CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        // Single bubble cycle; auto mode re-arms with the
                        // length captured at the original start.
                        if (r_auto_q) begin
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    crc_frame_counter #(
        .FRM_W (FRM_W)
    ) u_frame_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (1'b0),
        .i_inc   (w_frame_inc),
        .o_count (w_frames)
    );

    assign bus.busy     = r_busy;
    assign bus.shift_en = w_shift_en;
    assign bus.bit_idx  = r_bit_idx;
    assign bus.last     = w_last;
    assign bus.done     = r_done;
    assign bus.err_len  = r_err_len;
    assign bus.frames   = w_frames;

endmodule : crc_bit_sequencer

// File: tb/tb_crc_bit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_crc_bit_sequencer
// Scoreboard bench: each driven cycle pushes the predicted observable outputs
// into a queue; an independent monitor pops and compares every cycle.
// The reference model tracks a frame as "bits already shifted out of len"
// plus a pending-bubble flag and a completed-frame count.
// -----------------------------------------------------------------------------
module tb_crc_bit_sequencer;

    localparam int CNT_W = 8;
    localparam int FRM_W = 4;

    typedef struct packed {
        logic             busy;
        logic             shift_en;
        logic [CNT_W-1:0] bit_idx;
        logic             last;
        logic             done;
        logic             err_len;
        logic [FRM_W-1:0] frames;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    crc_bit_sequencer_if #(.CNT_W(CNT_W), .FRM_W(FRM_W)) bus ();

    crc_bit_sequencer #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    obs_t exp_q[$];

    // Reference model state
    bit m_in_frame;   // a frame is accepted and bits are still owed
    bit m_bubble;     // the cycle after the final bit
    int m_shifted;    // bits already shifted in the current frame
    int m_len;
    bit m_auto;
    int m_frames;     // completed frames, unbounded
    bit m_done_p;
    bit m_err_p;

    function automatic obs_t dut_obs();
        obs_t o;
        o.busy     = bus.busy;
        o.shift_en = bus.shift_en;
        o.bit_idx  = bus.bit_idx;
        o.last     = bus.last;
        o.done     = bus.done;
        o.err_len  = bus.err_len;
        o.frames   = bus.frames;
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_bubble = 0; m_shifted = 0; m_len = 0;
        m_auto = 0; m_frames = 0; m_done_p = 0; m_err_p = 0;
    endtask

    // Drive one cycle from the current negedge, predict, advance model,
    // and return at the next negedge.
    task automatic step(input bit s, input int l, input bit m, input bit v, input bit a);
        obs_t e;
        bit   sh;
        bus.start     = s;
        bus.len       = CNT_W'(l);
        bus.mode_auto = m;
        bus.in_valid  = v;
        bus.abort     = a;

        sh          = m_in_frame && v;
        e.busy      = m_in_frame || m_bubble;
        e.shift_en  = sh;
        e.bit_idx   = m_in_frame ? CNT_W'(m_shifted) : '0;
        e.last      = sh && (m_shifted == m_len - 1);
        e.done      = m_done_p;
        e.err_len   = m_err_p;
        e.frames    = FRM_W'(m_frames % (1 << FRM_W));
        exp_q.push_back(e);

        m_done_p = 0;
        m_err_p  = 0;
        if (a) begin
            m_in_frame = 0; m_bubble = 0; m_shifted = 0; m_auto = 0;
        end else if (m_bubble) begin
            m_bubble   = 0;
            m_in_frame = m_auto;
            m_shifted  = 0;
        end else if (m_in_frame) begin
            if (sh) begin
                m_shifted++;
                if (m_shifted == m_len) begin
                    m_in_frame = 0;
                    m_bubble   = 1;
                    m_shifted  = 0;
                    m_done_p   = 1;
                    m_frames++;
                end
            end
        end else if (s) begin
            if (l != 0) begin
                m_len = l; m_auto = m; m_shifted = 0; m_in_frame = 1;
            end else begin
                m_err_p = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.len = '0; bus.mode_auto = 0; bus.in_valid = 0; bus.abort = 0;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #3;
        idle_inputs();
        reset_n = 1'b0;
        #1;
        chk({tag, "_busy"},     int'(bus.busy),     0);
        chk({tag, "_shift_en"}, int'(bus.shift_en), 0);
        chk({tag, "_bit_idx"},  int'(bus.bit_idx),  0);
        chk({tag, "_last"},     int'(bus.last),     0);
        chk({tag, "_done"},     int'(bus.done),     0);
        chk({tag, "_err_len"},  int'(bus.err_len),  0);
        chk({tag, "_frames"},   int'(bus.frames),   0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic peek(input string name, input int frames_req, input int busy_req);
        #1;
        chk({name, "_frames"}, int'(bus.frames), frames_req);
        chk({name, "_busy"},   int'(bus.busy),   busy_req);
    endtask

    // Monitor: compares every cycle for which a prediction exists.
    initial begin
        obs_t e, g;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_obs();
                n_checks++;
                if (g !== e) begin
                    n_errors++;
                    $display("FAIL cycle_obs @%0t: got busy=%b sh=%b idx=%0d last=%b done=%b err=%b frames=%0d, expected busy=%b sh=%b idx=%0d last=%b done=%b err=%b frames=%0d",
                             $time, g.busy, g.shift_en, g.bit_idx, g.last, g.done, g.err_len, g.frames,
                             e.busy, e.shift_en, e.bit_idx, e.last, e.done, e.err_len, e.frames);
                end else if (e.done || e.err_len) begin
                    $display("txn @%0t: done=%b err_len=%b frames=%0d", $time, g.done, g.err_len, g.frames);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        do_reset("reset_init");

        // len=8, manual, in_valid constant
        step(1, 8, 0, 1, 0);
        repeat (10) step(0, 0, 0, 1, 0);
        peek("len8", 1, 0);

        // len=5, in_valid alternating 1,0
        step(1, 5, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, (i % 2) == 0, 0);
        peek("len5_toggle", 2, 0);

        // len=0 -> err_len only
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        peek("len0", 2, 0);

        // second start during RUN is ignored
        step(1, 4, 0, 1, 0);
        step(1, 9, 1, 1, 0);
        repeat (5) step(0, 0, 0, 1, 0);
        peek("start_in_run", 3, 0);

        // abort coinciding with last
        step(1, 4, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        peek("abort_last", 3, 0);
        step(0, 0, 0, 1, 0);

        // auto mode, len=3, 20 cycles -> 5 frames, then abort
        step(1, 3, 1, 1, 0);
        repeat (20) step(0, 0, 0, 1, 0);
        peek("auto3", 8, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        peek("auto3_abort", 8, 0);

        // frame counter wrap: 16 one-bit frames from reset
        do_reset("reset_wrap");
        step(1, 1, 1, 1, 0);
        repeat (30) step(0, 0, 0, 1, 0);
        peek("wrap15", 15, 1);
        repeat (2) step(0, 0, 0, 1, 0);
        peek("wrap16", 0, 1);
        step(0, 0, 0, 1, 1);

        // reset in the middle of a len=8 frame at bit_idx=3
        step(1, 8, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        #1;
        chk("midrun_bit_idx", int'(bus.bit_idx), 3);
        do_reset("reset_midrun");
        step(0, 0, 0, 1, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            int l;
            r = int'($urandom_range(0, 19));
            l = (r == 0) ? 0 : (r <= 16) ? r : 255 - int'($urandom_range(0, 2));
            step($urandom_range(0, 4) == 0, l, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end

        idle_inputs();
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_crc_bit_sequencer

// File: doc/crc_bit_sequencer.md
Name: crc_bit_sequencer

Overview:
Parametrised bit sequencer that paces a serial CRC engine. It counts a programmable number of data bits per frame and drives the engine's shift enable. It stalls on missing input valid and reports completion with a one-cycle done pulse. It supports single-frame and auto-repeat modes, abort, and a frame counter; it sits between the frame controller and the LFSR datapath.

Parameters:
CNT_W, 8, width of bit counter and length field (max frame length 2**CNT_W-1 bits)
FRM_W, 4, width of completed-frame counter

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  pulse; launches a frame when state is IDLE
len  input  CNT_W  bits per frame; sampled only on accepted start
mode_auto  input  1  sampled on accepted start; 1 = restart automatically after each frame
in_valid  input  1  serial bit available this cycle
abort  input  1  synchronous abort; highest priority after reset
busy  output  1  high in RUN or DONE
shift_en  output  1  combinational: state==RUN && in_valid
bit_idx  output  CNT_W  index of current bit (0..len_q-1)
last  output  1  combinational: shift_en && bit_idx==len_q-1
done  output  1  registered one-cycle pulse after the last bit shifts
err_len  output  1  registered one-cycle pulse: start accepted with len==0
frames  output  FRM_W  completed-frame count, wraps modulo 2**FRM_W

Behaviour:
- Reset (async, reset_n low): state IDLE; bit_idx=0, len_q=0, auto_q=0, done=0, err_len=0, frames=0. Outputs busy, shift_en and last are therefore 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, len!=0:
  - capture len_q=len and auto_q=mode_auto; bit_idx=0.
  - next state RUN; first shift_en is possible in the following cycle.
- IDLE, start=1, len==0:
  - err_len pulses next cycle; state stays IDLE; no shift_en; frames unchanged.
- RUN, in_valid=0: hold; bit_idx frozen, no shift.
- RUN, shift_en=1 and last=0: bit_idx+1.
- RUN, last=1: bit_idx<=0; next state DONE; done=1 in the next cycle (the cycle spent in DONE); frames+1 in the same cycle.
- DONE lasts exactly one cycle. Then:
  - auto_q=1: go to RUN, same len_q.
  - auto_q=0: go to IDLE.
  - No bit shifts during DONE (one bubble per frame).
- start outside IDLE: ignored; len and mode_auto are not resampled.
- abort=1 in any state:
  - next state IDLE, bit_idx=0, auto_q=0.
  - done and err_len are not asserted; frames unchanged.
  - If abort coincides with last, abort wins: no done and no frames increment.
  - abort together with start in IDLE: abort wins, start is dropped.
- To stop auto mode, the controller must use abort.
- len_q=1: every shift_en is also last. Frame = 1 RUN cycle + 1 DONE cycle.
- len_q=2**CNT_W-1: bit_idx reaches all-ones minus 1 and never overflows.
- frames wraps from 2**FRM_W-1 to 0 silently.
- Throughput with in_valid held high: len_q+1 cycles per frame in auto mode.
- No combinational path from start to any output. Only shift_en and last are combinational (from state, in_valid, bit_idx, len_q).

Decomposition:
- Shared package crc_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - default CNT_W/FRM_W constants, reused by the CRC LFSR and top-level controller.
- One natural sub-module: crc_frame_counter (FRM_W-wide wrap counter with increment enable and synchronous clear), instantiated for frames.
- The bit counter stays inline with the FSM.

Test Plan:
- Reset mid-RUN (bit_idx=3, len=8): assert reset_n low -> all outputs 0 immediately; state IDLE after release.
- start, len=8, mode_auto=0, in_valid=1 constant -> shift_en high 8 cycles, bit_idx 0..7, last on bit_idx=7, done 1 cycle later, busy low the cycle after, frames=1.
- len=5, in_valid toggled 1,0,1,0... -> exactly 5 shifts, bit_idx frozen on 0-cycles, done after 5th shift, no extra shifts.
- Auto mode, len=3, in_valid=1, 20 cycles -> repeating pattern of 3 shifts + 1 bubble, done every 4 cycles, frames=5. Then abort -> IDLE, frames held at 5.
- start with len=0 -> err_len pulse, busy stays 0, frames unchanged. A second start during RUN (len=4 active, start with len=9) -> ignored, frame still 4 bits.
- Abort in the same cycle as last (len=4) -> no done, frames unchanged, IDLE next cycle. With FRM_W=4, run 16 frames -> frames wraps to 0.
